bus_arbiter: RTL



---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_arbiter_rr_pick.sv | 29 ++
 rtl/bus_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int N_DEF     = 3;
   localparam int WIDTH_DEF = 3;

   // Index width that never collapses to zero bits for tiny counts.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping modulo N.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk from the farthest offset to the nearest so the nearest hit wins.
   always_comb begin
      valid = |req;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % N);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner/enable sequencer for a shared AND-OR bus with one dead cycle between owners.
// Optional per-owner grant limit and preempt pulse enabled by defining ARB_HOLD_LIMIT_EN.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int WIDTH    = WIDTH_DEF,
   parameter int HOLD_MAX = 4
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   data_in,
   output logic [N-1:0]         oe,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 preempt,
   output logic [WIDTH-1:0]     bus_out
);

   localparam int IW = $clog2(N);

   state_t        state_q, state_d;
   logic [N-1:0]  oe_q, oe_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic          busy_q, busy_d;
   logic [IW-1:0] last_q, last_d;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HW = idx_w(HOLD_MAX);
   logic [HW-1:0] hold_q, hold_d;
   logic          pre_q, pre_d;
`endif

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      oe_d    = oe_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      last_d  = last_q;
`ifdef ARB_HOLD_LIMIT_EN
      hold_d  = hold_q;
      pre_d   = 1'b0;
`endif
      case (state_q)
         IDLE, TURN: begin
            // TURN re-arbitrates directly so the owner gap is exactly one cycle.
            if (pick_valid) begin
               state_d = GRANT;
               oe_d    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
               gnt_d   = pick_idx;
               busy_d  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
               hold_d  = '0;
`endif
            end else begin
               state_d = IDLE;
               oe_d    = '0;
               busy_d  = 1'b0;
            end
         end
         GRANT: begin
            if (!req[gnt_q]) begin
               state_d = TURN;
               oe_d    = '0;
               busy_d  = 1'b0;
               last_d  = gnt_q;
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (hold_q == HW'(HOLD_MAX - 1)) begin
               state_d = TURN;
               oe_d    = '0;
               busy_d  = 1'b0;
               last_d  = gnt_q;
               pre_d   = 1'b1;
            end else begin
               hold_d  = hold_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            oe_d    = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         oe_q    <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         last_q  <= IW'(N - 1);
`ifdef ARB_HOLD_LIMIT_EN
         hold_q  <= '0;
         pre_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         oe_q    <= oe_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
`ifdef ARB_HOLD_LIMIT_EN
         hold_q  <= hold_d;
         pre_q   <= pre_d;
`endif
      end
   end

   assign oe     = oe_q;
   assign gnt_id = gnt_q;
   assign busy   = busy_q;
`ifdef ARB_HOLD_LIMIT_EN
   assign preempt = pre_q;
`else
   assign preempt = 1'b0;
`endif

   logic [WIDTH-1:0] masked [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign masked[gi] = data_in[gi*WIDTH +: WIDTH] & {WIDTH{oe_q[gi]}};
      end
   endgenerate

   always_comb begin
      bus_out = '0;
      for (int i = 0; i < N; i++) begin
         bus_out = bus_out | masked[i];
      end
   end

`ifndef SYNTHESIS
   a_oe_onehot0: assert property (@(posedge CLOCK) $onehot0(oe_q));
   a_hold_param: assert property (@(posedge CLOCK) HOLD_MAX >= 1);
`endif

endmodule
